qck_gate_sequencer: RTL and testbench

//  Per-channel QCK power-gating sequencer, directly upstream of the QCK gating controller.

---
 rtl/qck_gate_sequencer_pkg.sv | 17 +
 rtl/qck_gate_sequencer_if.sv | 50 +++++
 rtl/qck_gate_sequencer_chan.sv | 133 +++++++++++++
 rtl/qck_gate_sequencer.sv | 106 ++++++++++
 tb/tb_qck_gate_sequencer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/qck_gate_sequencer_pkg.sv
// qck_pkg: shared state encoding and default widths for the QCK gate sequencer.
// Optional build macro: QCK_SEQ_STATS_EN (enables per-channel gate event counters).
package qck_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    ENTRY  = 2'd1,
    GATED  = 2'd2,
    EXIT   = 2'd3
  } qck_seq_state_e;

  localparam int QCK_CHANNELS    = 8;
  localparam int QCK_DELAY_WIDTH = 4;
  localparam int QCK_IDLE_WIDTH  = 8;
  localparam int QCK_CNT_WIDTH   = 16;

endpackage

// File: rtl/qck_gate_sequencer_if.sv
// Request/status bundle between the requesting agent (master) and the
// sequencer (slave). gate_cnt exists only when QCK_SEQ_STATS_EN is defined.
interface qck_gate_sequencer_if #(
  parameter int CHANNELS    = qck_pkg::QCK_CHANNELS,
  parameter int DELAY_WIDTH = qck_pkg::QCK_DELAY_WIDTH,
  parameter int IDLE_WIDTH  = qck_pkg::QCK_IDLE_WIDTH
`ifdef QCK_SEQ_STATS_EN
  ,
  parameter int CNT_WIDTH   = qck_pkg::QCK_CNT_WIDTH
`endif
);

  logic [CHANNELS-1:0]             idle_req;
  logic [CHANNELS-1:0]             wake_req;
  logic [CHANNELS-1:0]             urgent_req;
  logic [CHANNELS*DELAY_WIDTH-1:0] entry_dly;
  logic [CHANNELS*DELAY_WIDTH-1:0] exit_dly;
  logic [IDLE_WIDTH-1:0]           min_idle;
  logic                            err_clr;
  logic [CHANNELS-1:0]             ck_en;
  logic [CHANNELS-1:0]             qck_mask;
  logic [CHANNELS-1:0]             skip_req;
  logic [CHANNELS-1:0]             gated;
  logic [CHANNELS-1:0]             wake_ack;
  logic [CHANNELS-1:0]             seq_err;
`ifdef QCK_SEQ_STATS_EN
  logic [CHANNELS*CNT_WIDTH-1:0]   gate_cnt;
`endif

`ifdef QCK_SEQ_STATS_EN
  modport master (
    output idle_req, wake_req, urgent_req, entry_dly, exit_dly, min_idle, err_clr,
    input  ck_en, qck_mask, skip_req, gated, wake_ack, seq_err, gate_cnt
  );
  modport slave (
    input  idle_req, wake_req, urgent_req, entry_dly, exit_dly, min_idle, err_clr,
    output ck_en, qck_mask, skip_req, gated, wake_ack, seq_err, gate_cnt
  );
`else
  modport master (
    output idle_req, wake_req, urgent_req, entry_dly, exit_dly, min_idle, err_clr,
    input  ck_en, qck_mask, skip_req, gated, wake_ack, seq_err
  );
  modport slave (
    input  idle_req, wake_req, urgent_req, entry_dly, exit_dly, min_idle, err_clr,
    output ck_en, qck_mask, skip_req, gated, wake_ack, seq_err
  );
`endif

endinterface

// File: rtl/qck_gate_sequencer_chan.sv
// qck_seq_chan: one channel of the gating sequence
// (idle qualification -> entry window -> gated -> exit window).
// Outputs are registered from the next state. With QCK_SEQ_STATS_EN an
// ENTRY->GATED event strobe is exported for the top-level counters.
module qck_seq_chan
  import qck_pkg::*;
#(
  parameter int DELAY_WIDTH = QCK_DELAY_WIDTH,
  parameter int IDLE_WIDTH  = QCK_IDLE_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_idle,
  input  logic                   i_wake,
  input  logic                   i_urgent,
  input  logic [DELAY_WIDTH-1:0] i_entry_dly,
  input  logic [DELAY_WIDTH-1:0] i_exit_dly,
  input  logic [IDLE_WIDTH-1:0]  i_min_idle,
  output logic                   o_ck_en,
  output logic                   o_qck_mask,
  output logic                   o_gated,
  output logic                   o_wake_ack
`ifdef QCK_SEQ_STATS_EN
  ,
  output logic                   o_gate_evt
`endif
);

  localparam logic [DELAY_WIDTH-1:0] DLY_ONE  = {{(DELAY_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [IDLE_WIDTH-1:0]  IDLE_ONE = {{(IDLE_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [IDLE_WIDTH-1:0]  IDLE_MAX = {IDLE_WIDTH{1'b1}};

  qck_seq_state_e         r_state;
  logic [IDLE_WIDTH-1:0]  r_idle_cnt;
  logic [DELAY_WIDTH-1:0] r_dly_cnt;
  logic                   r_ck_en;
  logic                   r_qck_mask;
  logic                   r_gated;
  logic                   r_wake_ack;
  logic                   w_idle_qual;

  // Idle only counts when neither a wake nor an urgent request competes with it.
  assign w_idle_qual = i_idle & ~i_wake & ~i_urgent;

  // Channel FSM with counters; outputs default to the ACTIVE pattern and are
  // overridden whenever the next state is ENTRY, GATED or EXIT.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= ACTIVE;
      r_idle_cnt <= '0;
      r_dly_cnt  <= '0;
      r_ck_en    <= 1'b0;
      r_qck_mask <= 1'b0;
      r_gated    <= 1'b0;
      r_wake_ack <= 1'b0;
    end else begin
      r_ck_en    <= 1'b1;
      r_qck_mask <= 1'b0;
      r_gated    <= 1'b0;
      r_wake_ack <= 1'b0;
      case (r_state)
        ACTIVE: begin
          if (w_idle_qual) begin
            if (r_idle_cnt >= i_min_idle) begin
              r_state    <= ENTRY;
              r_dly_cnt  <= i_entry_dly;
              r_idle_cnt <= '0;
              r_qck_mask <= 1'b1;
            end else if (r_idle_cnt != IDLE_MAX) begin
              r_idle_cnt <= r_idle_cnt + IDLE_ONE;
            end
          end else begin
            r_idle_cnt <= '0;
          end
        end
        ENTRY: begin
          r_idle_cnt <= '0;
          if (i_urgent || i_wake) begin
            r_state    <= ACTIVE;
            r_wake_ack <= 1'b1;
          end else if (r_dly_cnt == '0) begin
            r_state    <= GATED;
            r_ck_en    <= 1'b0;
            r_qck_mask <= 1'b1;
            r_gated    <= 1'b1;
          end else begin
            r_dly_cnt  <= r_dly_cnt - DLY_ONE;
            r_qck_mask <= 1'b1;
          end
        end
        GATED: begin
          r_idle_cnt <= '0;
          if (i_urgent) begin
            r_state    <= ACTIVE;
            r_wake_ack <= 1'b1;
          end else if (i_wake) begin
            r_state    <= EXIT;
            r_dly_cnt  <= i_exit_dly;
            r_qck_mask <= 1'b1;
          end else begin
            r_ck_en    <= 1'b0;
            r_qck_mask <= 1'b1;
            r_gated    <= 1'b1;
          end
        end
        EXIT: begin
          r_idle_cnt <= '0;
          if (i_urgent || (r_dly_cnt == '0)) begin
            r_state    <= ACTIVE;
            r_wake_ack <= 1'b1;
          end else begin
            r_dly_cnt  <= r_dly_cnt - DLY_ONE;
            r_qck_mask <= 1'b1;
          end
        end
        default: begin
          r_state <= ACTIVE;
        end
      endcase
    end
  end

  assign o_ck_en    = r_ck_en;
  assign o_qck_mask = r_qck_mask;
  assign o_gated    = r_gated;
  assign o_wake_ack = r_wake_ack;

`ifdef QCK_SEQ_STATS_EN
  // Strobe for the cycle whose edge completes ENTRY -> GATED.
  assign o_gate_evt = (r_state == ENTRY) && !i_urgent && !i_wake && (r_dly_cnt == '0);
`endif

endmodule

// File: rtl/qck_gate_sequencer.sv
// qck_gate_sequencer: per-channel QCK power-gating sequencer feeding the
// QCK gating controller. Instantiates one qck_seq_chan per channel and holds
// the skip_req delay flops, the sticky seq_err flags and, when
// QCK_SEQ_STATS_EN is defined, the per-channel gate_cnt counters.
module qck_gate_sequencer
  import qck_pkg::*;
#(
  parameter int CHANNELS    = QCK_CHANNELS,
  parameter int DELAY_WIDTH = QCK_DELAY_WIDTH,
  parameter int IDLE_WIDTH  = QCK_IDLE_WIDTH
`ifdef QCK_SEQ_STATS_EN
  ,
  parameter int CNT_WIDTH   = QCK_CNT_WIDTH
`endif
) (
  input logic                 clk,
  input logic                 reset_n,
  qck_gate_sequencer_if.slave bus
);

  logic [CHANNELS-1:0] w_ck_en;
  logic [CHANNELS-1:0] w_qck_mask;
  logic [CHANNELS-1:0] w_gated;
  logic [CHANNELS-1:0] w_wake_ack;
  logic [CHANNELS-1:0] w_conflict;
  logic [CHANNELS-1:0] r_skip_req;
  logic [CHANNELS-1:0] r_seq_err;
`ifdef QCK_SEQ_STATS_EN
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  logic [CHANNELS-1:0]           w_gate_evt;
  logic [CNT_WIDTH-1:0]          r_gate_cnt [CHANNELS];
  logic [CHANNELS*CNT_WIDTH-1:0] w_gate_cnt;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      qck_seq_chan #(
        .DELAY_WIDTH (DELAY_WIDTH),
        .IDLE_WIDTH  (IDLE_WIDTH)
      ) u_chan (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_idle      (bus.idle_req[gi]),
        .i_wake      (bus.wake_req[gi]),
        .i_urgent    (bus.urgent_req[gi]),
        .i_entry_dly (bus.entry_dly[gi*DELAY_WIDTH +: DELAY_WIDTH]),
        .i_exit_dly  (bus.exit_dly[gi*DELAY_WIDTH +: DELAY_WIDTH]),
        .i_min_idle  (bus.min_idle),
        .o_ck_en     (w_ck_en[gi]),
        .o_qck_mask  (w_qck_mask[gi]),
        .o_gated     (w_gated[gi]),
        .o_wake_ack  (w_wake_ack[gi])
`ifdef QCK_SEQ_STATS_EN
        ,
        .o_gate_evt  (w_gate_evt[gi])
`endif
      );

`ifdef QCK_SEQ_STATS_EN
      // Count ENTRY->GATED transitions; wraps naturally, cleared only by reset.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_gate_cnt[gi] <= '0;
        end else if (w_gate_evt[gi]) begin
          r_gate_cnt[gi] <= r_gate_cnt[gi] + CNT_ONE;
        end
      end

      assign w_gate_cnt[gi*CNT_WIDTH +: CNT_WIDTH] = r_gate_cnt[gi];
`endif
    end
  endgenerate

  // A channel asking to idle and wake in the same cycle is a request conflict.
  assign w_conflict = bus.idle_req & bus.wake_req;

  // skip_req mirrors urgent_req one cycle later regardless of channel state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_skip_req <= '0;
    end else begin
      r_skip_req <= bus.urgent_req;
    end
  end

  // Sticky conflict flags; a new conflict wins over a simultaneous err_clr.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_seq_err <= '0;
    end else begin
      r_seq_err <= w_conflict | (r_seq_err & ~{CHANNELS{bus.err_clr}});
    end
  end

  assign bus.ck_en    = w_ck_en;
  assign bus.qck_mask = w_qck_mask;
  assign bus.gated    = w_gated;
  assign bus.wake_ack = w_wake_ack;
  assign bus.skip_req = r_skip_req;
  assign bus.seq_err  = r_seq_err;
`ifdef QCK_SEQ_STATS_EN
  assign bus.gate_cnt = w_gate_cnt;
`endif

endmodule

// File: tb/tb_qck_gate_sequencer.sv
// Self-checking bench for qck_gate_sequencer: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural per-channel model. Build with QCK_SEQ_STATS_EN to also check gate_cnt.
module tb_qck_gate_sequencer;

  localparam int NCH = 8;

  logic clk;
  logic reset_n;

  qck_gate_sequencer_if u_if ();

  qck_gate_sequencer u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  // Behavioural model: mode 0=running, 1=entry window, 2=gated, 3=exit window.
  int          m_mode [NCH];
  int          m_run  [NCH];  // consecutive qualifying idle cycles, current one included
  int          m_win  [NCH];  // length in cycles of the current window
  int          m_el   [NCH];  // edges elapsed inside the current window
  int          m_gcnt [NCH];
  bit          m_ack  [NCH];
  bit          m_err  [NCH];
  bit          m_skip [NCH];
  bit          m_rst;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_step();
    logic [NCH-1:0] idl, wk, ug;
    int edly, xdly;
    idl = u_if.idle_req;
    wk  = u_if.wake_req;
    ug  = u_if.urgent_req;
    if (!reset_n) begin
      m_rst = 1'b1;
      for (int ch = 0; ch < NCH; ch++) begin
        m_mode[ch] = 0; m_run[ch] = 0; m_win[ch] = 0; m_el[ch] = 0;
        m_gcnt[ch] = 0; m_ack[ch] = 1'b0; m_err[ch] = 1'b0; m_skip[ch] = 1'b0;
      end
    end else begin
      m_rst = 1'b0;
      for (int ch = 0; ch < NCH; ch++) begin
        edly = int'(u_if.entry_dly[ch*4 +: 4]);
        xdly = int'(u_if.exit_dly[ch*4 +: 4]);
        m_ack[ch] = 1'b0;
        if (m_mode[ch] == 0) begin
          if (idl[ch] && !wk[ch] && !ug[ch]) begin
            m_run[ch]++;
            if (m_run[ch] > int'(u_if.min_idle)) begin
              m_mode[ch] = 1; m_win[ch] = edly + 1; m_el[ch] = 0; m_run[ch] = 0;
            end
          end else begin
            m_run[ch] = 0;
          end
        end else if (m_mode[ch] == 1) begin
          if (ug[ch] || wk[ch]) begin
            m_mode[ch] = 0; m_ack[ch] = 1'b1;
          end else begin
            m_el[ch]++;
            if (m_el[ch] == m_win[ch]) begin
              m_mode[ch] = 2;
              m_gcnt[ch] = (m_gcnt[ch] + 1) % 65536;
            end
          end
        end else if (m_mode[ch] == 2) begin
          if (ug[ch]) begin
            m_mode[ch] = 0; m_ack[ch] = 1'b1;
          end else if (wk[ch]) begin
            m_mode[ch] = 3; m_win[ch] = xdly + 1; m_el[ch] = 0;
          end
        end else begin
          if (ug[ch]) begin
            m_mode[ch] = 0; m_ack[ch] = 1'b1;
          end else begin
            m_el[ch]++;
            if (m_el[ch] == m_win[ch]) begin
              m_mode[ch] = 0; m_ack[ch] = 1'b1;
            end
          end
        end
        m_skip[ch] = ug[ch];
        if (idl[ch] && wk[ch]) m_err[ch] = 1'b1;
        else if (u_if.err_clr) m_err[ch] = 1'b0;
      end
    end
  endtask

  // The single compare point: every cycle, all DUT outputs against the model.
  task automatic compare_model();
    logic [NCH-1:0] e_ck, e_mask, e_gated, e_ack, e_skip, e_err;
    for (int ch = 0; ch < NCH; ch++) begin
      e_ck[ch]    = !m_rst && (m_mode[ch] != 2);
      e_mask[ch]  = !m_rst && (m_mode[ch] != 0);
      e_gated[ch] = !m_rst && (m_mode[ch] == 2);
      e_ack[ch]   = m_ack[ch];
      e_skip[ch]  = m_skip[ch];
      e_err[ch]   = m_err[ch];
    end
    chk("model ck_en",    u_if.ck_en,    e_ck);
    chk("model qck_mask", u_if.qck_mask, e_mask);
    chk("model gated",    u_if.gated,    e_gated);
    chk("model wake_ack", u_if.wake_ack, e_ack);
    chk("model skip_req", u_if.skip_req, e_skip);
    chk("model seq_err",  u_if.seq_err,  e_err);
`ifdef QCK_SEQ_STATS_EN
    for (int ch = 0; ch < NCH; ch++)
      chk("model gate_cnt", u_if.gate_cnt[ch*16 +: 16], m_gcnt[ch][15:0]);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  initial begin
    int idle_cycles, mask_cycles, gate_rises;
    logic prev_g4;
    n_pass  = 0;
    n_total = 0;
    reset_n = 1'b0;
    u_if.idle_req   = '0;
    u_if.wake_req   = '0;
    u_if.urgent_req = '0;
    u_if.entry_dly  = 32'h2222_2222;
    u_if.exit_dly   = 32'h3333_3333;
    u_if.min_idle   = 8'd4;
    u_if.err_clr    = 1'b0;

    // 1: reset holds every output low, release gives ACTIVE outputs
    repeat (3) step();
    chk("reset ck_en", u_if.ck_en, 8'h00);
    chk("reset qck_mask", u_if.qck_mask, 8'h00);
    chk("reset wake_ack", u_if.wake_ack, 8'h00);
    reset_n = 1'b1;
    step();
    chk("release ck_en", u_if.ck_en, 8'hFF);
    chk("release qck_mask", u_if.qck_mask, 8'h00);

    // 2: ch0 qualifies for 4 idle cycles, masks for 3, then gates
    u_if.idle_req = 8'h01;
    idle_cycles = 0; mask_cycles = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (u_if.gated[0]) break;
      if (u_if.qck_mask[0]) mask_cycles++;
      else idle_cycles++;
    end
    chk("t2 idle cycles", idle_cycles, 4);
    chk("t2 mask cycles", mask_cycles, 3);
    chk("t2 ck_en", u_if.ck_en, 8'hFE);
    chk("t2 gated", u_if.gated, 8'h01);
    u_if.idle_req = 8'h00;

    // 3: wake pulse opens a 4-cycle exit window, then wake_ack
    u_if.wake_req = 8'h01;
    step();
    chk("t3 ck_en", u_if.ck_en, 8'hFF);
    chk("t3 qck_mask", u_if.qck_mask, 8'h01);
    u_if.wake_req = 8'h00;
    mask_cycles = 1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (!u_if.qck_mask[0]) break;
      mask_cycles++;
    end
    chk("t3 mask cycles", mask_cycles, 4);
    chk("t3 wake_ack", u_if.wake_ack, 8'h01);
    step();
    chk("t3 wake_ack pulse", u_if.wake_ack, 8'h00);

    // 4: urgent aborts ch2 entry window, skip_req follows urgent by one cycle
    u_if.min_idle  = 8'd0;
    u_if.entry_dly = 32'h2222_2522;
    u_if.idle_req  = 8'h04;
    step();
    chk("t4 entry mask", u_if.qck_mask, 8'h04);
    u_if.idle_req   = 8'h00;
    u_if.urgent_req = 8'h04;
    step();
    chk("t4 abort mask", u_if.qck_mask, 8'h00);
    chk("t4 wake_ack", u_if.wake_ack, 8'h04);
    chk("t4 skip_req", u_if.skip_req, 8'h04);
    step();
    chk("t4 skip held", u_if.skip_req, 8'h04);
    u_if.urgent_req = 8'h00;
    step();
    chk("t4 skip drop", u_if.skip_req, 8'h00);

    // 5: idle+wake conflict, clear, and set-beats-clear
    u_if.idle_req = 8'h08; u_if.wake_req = 8'h08;
    step();
    chk("t5 seq_err set", u_if.seq_err, 8'h08);
    chk("t5 stays active", u_if.qck_mask, 8'h00);
    u_if.idle_req = 8'h00; u_if.wake_req = 8'h00; u_if.err_clr = 1'b1;
    step();
    chk("t5 seq_err clr", u_if.seq_err, 8'h00);
    u_if.idle_req = 8'h08; u_if.wake_req = 8'h08;
    step();
    chk("t5 set beats clr", u_if.seq_err, 8'h08);
    u_if.idle_req = 8'h00; u_if.wake_req = 8'h00; u_if.err_clr = 1'b0;

    // 6: reset in the middle of ch4 exit window, then three gate cycles
    u_if.entry_dly = 32'h0000_0000;
    u_if.exit_dly  = 32'h0005_0000;
    u_if.idle_req  = 8'h10;
    step();
    u_if.idle_req = 8'h00;
    step();
    chk("t6 gated", u_if.gated, 8'h10);
    u_if.wake_req = 8'h10;
    step();
    u_if.wake_req = 8'h00;
    step();
    reset_n = 1'b0;
    step();
    chk("t6 reset ck_en", u_if.ck_en, 8'h00);
    chk("t6 reset qck_mask", u_if.qck_mask, 8'h00);
    chk("t6 reset wake_ack", u_if.wake_ack, 8'h00);
    reset_n = 1'b1;
    step();
    chk("t6 release ck_en", u_if.ck_en, 8'hFF);
    u_if.exit_dly = 32'h0;
    gate_rises = 0; prev_g4 = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int ph = 0; ph < 4; ph++) begin
        u_if.idle_req = (ph == 0) ? 8'h10 : 8'h00;
        u_if.wake_req = (ph == 2) ? 8'h10 : 8'h00;
        step();
        if (u_if.gated[4] && !prev_g4) gate_rises++;
        prev_g4 = u_if.gated[4];
      end
    end
    u_if.idle_req = 8'h00; u_if.wake_req = 8'h00;
    chk("t6 gate rises", gate_rises, 3);
    chk("t6 final wake_ack", u_if.wake_ack, 8'h10);
`ifdef QCK_SEQ_STATS_EN
    chk("t6 gate_cnt4", u_if.gate_cnt[4*16 +: 16], 16'd3);
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      reset_n = ($urandom_range(0, 299) != 0);
      for (int ch = 0; ch < NCH; ch++) begin
        u_if.idle_req[ch]   = ($urandom_range(0, 3) != 0);
        u_if.wake_req[ch]   = ($urandom_range(0, 15) == 0);
        u_if.urgent_req[ch] = ($urandom_range(0, 39) == 0);
      end
      if ($urandom_range(0, 49) == 0) u_if.min_idle = 8'($urandom_range(0, 6));
      u_if.entry_dly = $urandom;
      u_if.exit_dly  = $urandom;
      u_if.err_clr   = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
